// File: rtl/nios_simple_fifo_pkg.sv
// Shared definitions for the nios_simple parametrised stream FIFO:
// default geometry, sideband bit positions and a constant clog2 helper.
package nios_simple_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 36;
  localparam int DEFAULT_DEPTH      = 8;

  // Packet sideband bits sit directly above the payload in each stored word.
  localparam int SIDEBAND_BITS = 2;
  localparam int EOP_OFFSET    = 0;
  localparam int SOP_OFFSET    = 1;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nios_simple_fifo_ram.sv
// Simple dual-port storage for the stream FIFO: one write port and one
// registered read port whose output only changes when a read is enabled.
module nios_simple_fifo_ram
  import nios_simple_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEFAULT_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array has no reset; stale contents are never fetched.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register doubles as the FIFO output register, so it holds while idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nios_simple_param_stream_fifo.sv
// Parametrised single-clock Avalon-ST FIFO with watermark flags and flush.
// Optional packet sideband (SOP/EOP plus complete-packet counter) is built
// when the macro NIOS_SIMPLE_FIFO_PACKET_EN is defined.
// The word sitting in the output register still counts toward fill_level;
// its RAM slot is released as soon as it is fetched.
module nios_simple_param_stream_fifo
  import nios_simple_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 1,
  localparam int ADDR_WIDTH  = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef NIOS_SIMPLE_FIFO_PACKET_EN
  ,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [ADDR_WIDTH:0]   packet_count
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
`ifdef NIOS_SIMPLE_FIFO_PACKET_EN
  localparam int WORD_WIDTH = DATA_WIDTH + SIDEBAND_BITS;
`else
  localparam int WORD_WIDTH = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(ALMOST_EMPTY);

  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  almost_full_q, almost_empty_q;
  logic [CW-1:0]         mem_count;
  logic                  wr_fire, rd_fire, fetch;
  logic [WORD_WIDTH-1:0] wr_word, rd_word;

  assign in_ready  = !clear && (count_q != FULL_COUNT);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid_q && out_ready && !clear;
  assign mem_count = count_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign fetch     = !clear && (mem_count != '0) && (!out_valid_q || out_ready);

  // Pack payload and optional sideband into one stored word.
  always_comb begin
    wr_word = '0;
    wr_word[DATA_WIDTH-1:0] = in_data;
`ifdef NIOS_SIMPLE_FIFO_PACKET_EN
    wr_word[DATA_WIDTH+SOP_OFFSET] = in_startofpacket;
    wr_word[DATA_WIDTH+EOP_OFFSET] = in_endofpacket;
`endif
  end

  nios_simple_fifo_ram #(
    .WIDTH      (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  // Next-state for pointers, occupancy and output valid; clear overrides all.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (fetch) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (fetch) begin
        out_valid_d = 1'b1;
      end else if (rd_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; watermarks derive from next-state count to track fill_level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      out_valid_q    <= out_valid_d;
      almost_full_q  <= (count_d >= AF_LEVEL);
      almost_empty_q <= (count_d <= AE_LEVEL);
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = rd_word[DATA_WIDTH-1:0];
  assign fill_level   = count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

`ifdef NIOS_SIMPLE_FIFO_PACKET_EN
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          eop_wr, eop_rd;

  assign eop_wr = wr_fire && in_endofpacket;
  assign eop_rd = rd_fire && rd_word[DATA_WIDTH+EOP_OFFSET];

  // Complete packets held: one per EOP written, released when its EOP is read.
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (clear) begin
      pkt_count_d = '0;
    end else begin
      case ({eop_wr, eop_rd})
        2'b10:   pkt_count_d = pkt_count_q + CW'(1);
        2'b01:   pkt_count_d = pkt_count_q - CW'(1);
        default: pkt_count_d = pkt_count_q;
      endcase
    end
  end

  // Packet counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign out_startofpacket = rd_word[DATA_WIDTH+SOP_OFFSET];
  assign out_endofpacket   = rd_word[DATA_WIDTH+EOP_OFFSET];
  assign packet_count      = pkt_count_q;
`endif

endmodule
